signed_divider: RTL and testbench
=================================

Name: signed_divider

Overview:
- Iterative two's-complement signed integer divider, the inverse-direction companion to the Baugh-Wooley multiplier datapath.
- Produces one quotient bit per clock using a non-restoring or restoring shift-subtract core on operand magnitudes, then applies a sign fix-up.
- Sits beside the multiplier as a shared arithmetic unit with a start/busy/done handshake.
- Results must match SystemVerilog signed `/` and `%`: truncation toward zero, remainder takes the sign of the dividend.

Parameters:
- N, 8, operand, quotient and remainder width in bits (N >= 2).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- start_in  input  1  request; sampled only while busy_out=0 and done_out=0.
- dividend_in  input  N  signed dividend; captured on the accepting edge only.
- divisor_in  input  N  signed divisor; captured on the accepting edge only.
- busy_out  output  1  high while an operation is in progress.
- done_out  output  1  single-cycle completion pulse.
- quotient_out  output  N  signed quotient; held until the next completion.
- remainder_out  output  N  signed remainder; held until the next completion.
- div_by_zero_out  output  1  high with results of a divide-by-zero op; held until next completion.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy_out=0, done_out=0, quotient_out=0, remainder_out=0, div_by_zero_out=0; all internal registers cleared.
- States:
  - IDLE: start_in=1 at edge E captures operands, records signs, computes magnitudes (N+1-bit internal so |-2^(N-1)| is representable), loads counter=N, goes to CALC; busy_out=1 after E.
  - CALC: one shift-subtract step per edge, counter decrements; after the N-th step goes to FIX.
  - FIX: negate quotient if dividend sign != divisor sign; negate remainder if dividend negative; register outputs, pulse done_out, go to DONE.
  - DONE: one cycle with done_out=1 and busy_out=0, then IDLE.
- Latency: done_out is high in the cycle following edge E+N+1, exactly one cycle long. busy_out is high from after E through edge E+N+1, so busy_out and done_out are never high together.
- Divisor zero: detected in IDLE at E. Skips CALC and goes directly to FIX, so done_out follows edge E+1.
  - quotient_out = all ones (-1), remainder_out = captured dividend, div_by_zero_out=1.
- Overflow case -2^(N-1) / -1: quotient_out = -2^(N-1) (wraps), remainder_out=0, div_by_zero_out=0, normal latency.
- start_in while busy_out=1 or done_out=1 is ignored; no queuing.
- Operand changes after E have no effect on the running op.
- Outputs change only at a FIX edge or at reset. div_by_zero_out clears at the next non-zero-divisor completion.
- Reset asserted mid-operation aborts immediately; no done_out pulse; next start behaves as from fresh reset.
- Zero dividend: quotient 0, remainder 0, full latency.

Test Plan:
- Reset, then N=8, 100/7 -> after 10 edges done_out pulse; quotient 14 (0x0E), remainder 2; busy_out low in done cycle.
- Sign matrix: -100/7 -> q 0xF2 (-14), r 0xFE (-2). 100/-7 -> q 0xF2, r 0x02. -100/-7 -> q 0x0E, r 0xFE.
- Boundaries: -128/-1 -> q 0x80, r 0, dbz 0. -128/1 -> q 0x80, r 0. 7/100 -> q 0, r 7.
- 5/0 -> done_out after 2 edges; q 0xFF, r 0x05, dbz 1. A following 9/3 -> q 3, r 0, dbz 0.
- Start 100/7, pulse start_in with 50/5 at cycles 3 and 9 -> only one done; result 14/2. Operands changed mid-op also ignored.
- Start 100/7, assert rst_n_in at cycle 4 -> outputs immediately 0, no done. After release, 20/6 -> q 3, r 2.
- Random sweep of all signed pairs vs `/` and `%` (excluding divisor 0) -> zero mismatches.

Source files
------------

// File: rtl/signed_divider_if.sv
// Start/busy/done handshake and operand/result bus of the iterative signed divider.
interface signed_divider_if #(
    parameter int N = 8
);
    logic         start_in;
    logic [N-1:0] dividend_in;
    logic [N-1:0] divisor_in;
    logic         busy_out;
    logic         done_out;
    logic [N-1:0] quotient_out;
    logic [N-1:0] remainder_out;
    logic         div_by_zero_out;

    modport master (
        output start_in, dividend_in, divisor_in,
        input  busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
    );

    modport slave (
        input  start_in, dividend_in, divisor_in,
        output busy_out, done_out, quotient_out, remainder_out, div_by_zero_out
    );
endinterface

// File: rtl/signed_divider.sv
// Iterative two's-complement divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, then a sign fix-up matching SV signed / and %.
module signed_divider #(
    parameter int N = 8
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    signed_divider_if.slave bus
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N:0]    ONE_W = (N + 1)'(1);
    localparam logic [N-1:0]  ONE_N = N'(1);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0] count;
    logic [N-1:0]  rem_acc;
    logic [N-1:0]  quo_acc;
    logic [N:0]    dvs_mag;
    logic [N-1:0]  dividend_hold;
    logic          sign_dvd;
    logic          sign_dvs;
    logic          zero_div;

    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          dbz_reg;

    logic          accept;
    logic [N-1:0]  dvd_mag_in;
    logic [N:0]    dvs_ext;
    logic [N:0]    dvs_mag_in;
    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          take;
    logic [N-1:0]  quo_fix;
    logic [N-1:0]  rem_fix;

    // An N-bit unsigned magnitude still holds 2^(N-1); the divisor is kept N+1 wide for the subtract.
    always_comb begin
        accept     = (state == IDLE) && bus.start_in;
        dvd_mag_in = bus.dividend_in[N-1] ? (~bus.dividend_in + ONE_N) : bus.dividend_in;
        dvs_ext    = {bus.divisor_in[N-1], bus.divisor_in};
        dvs_mag_in = bus.divisor_in[N-1] ? (~dvs_ext + ONE_W) : dvs_ext;
    end

    // The partial remainder stays below the divisor, so the difference sign bit decides the step.
    always_comb begin
        shifted = {rem_acc, quo_acc[N-1]};
        diff    = shifted - dvs_mag;
        take    = ~diff[N];
        quo_fix = (sign_dvd ^ sign_dvs) ? (~quo_acc + ONE_N) : quo_acc;
        rem_fix = sign_dvd ? (~rem_acc + ONE_N) : rem_acc;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start_in) begin
                    state_next = (bus.divisor_in == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (count == ONE_C) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count         <= '0;
            rem_acc       <= '0;
            quo_acc       <= '0;
            dvs_mag       <= '0;
            dividend_hold <= '0;
            sign_dvd      <= 1'b0;
            sign_dvs      <= 1'b0;
            zero_div      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            if (accept) begin
                count         <= CW'(N);
                rem_acc       <= '0;
                quo_acc       <= dvd_mag_in;
                dvs_mag       <= dvs_mag_in;
                dividend_hold <= bus.dividend_in;
                sign_dvd      <= bus.dividend_in[N-1];
                sign_dvs      <= bus.divisor_in[N-1];
                zero_div      <= (bus.divisor_in == '0);
            end
            if (state == CALC) begin
                count   <= count - ONE_C;
                rem_acc <= take ? diff[N-1:0] : shifted[N-1:0];
                quo_acc <= {quo_acc[N-2:0], take};
            end
            // Result registers only move here, so they hold between completions.
            if (state == FIX) begin
                if (zero_div) begin
                    quotient_reg  <= '1;
                    remainder_reg <= dividend_hold;
                    dbz_reg       <= 1'b1;
                end else begin
                    quotient_reg  <= quo_fix;
                    remainder_reg <= rem_fix;
                    dbz_reg       <= 1'b0;
                end
            end
        end
    end

    assign bus.busy_out        = (state == CALC) || (state == FIX);
    assign bus.done_out        = (state == DONE);
    assign bus.quotient_out    = quotient_reg;
    assign bus.remainder_out   = remainder_reg;
    assign bus.div_by_zero_out = dbz_reg;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed sign/boundary cases plus a random sweep
// against an integer-arithmetic reference.
module tb_signed_divider;
    localparam int N = 8;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk_in = ~clk_in;

    signed_divider_if #(.N(N)) bus ();

    signed_divider #(.N(N)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // Reference: plain integer division truncates toward zero and avoids the 8-bit overflow case.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        if (ib == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = N'(ia / ib);
            r = N'(ia % ib);
            z = 1'b0;
        end
    endtask

    // Issues one operation, scrambles operands after acceptance, and waits (bounded) for done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic z, output int lat);
        int overlap;
        overlap = 0;
        @(negedge clk_in);
        bus.dividend_in = a;
        bus.divisor_in  = b;
        bus.start_in    = 1'b1;
        @(posedge clk_in);
        #1;
        bus.start_in    = 1'b0;
        bus.dividend_in = N'($urandom);
        bus.divisor_in  = N'($urandom);
        lat = 0;
        while (!bus.done_out && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (bus.busy_out && bus.done_out) overlap++;
        end
        q = bus.quotient_out;
        r = bus.remainder_out;
        z = bus.div_by_zero_out;
        n_checks++;
        if (!bus.done_out) begin
            n_fail++;
            $display("[TB] FAIL done_timeout: done_out=%0b after %0d edges, required 1", bus.done_out, lat);
        end
        n_checks++;
        if (overlap !== 0 || bus.busy_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_in_done: busy_out=%0b overlaps=%0d, required 0", bus.busy_out, overlap);
        end
        @(posedge clk_in);
        #1;
        n_checks++;
        if (bus.done_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL done_width: done_out=%0b one cycle later, required 0", bus.done_out);
        end
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy_out, bus.done_out, bus.quotient_out, bus.remainder_out, bus.div_by_zero_out} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: busy=%0b done=%0b q=%h r=%h dbz=%0b, required all 0",
                     bus.busy_out, bus.done_out, bus.quotient_out, bus.remainder_out, bus.div_by_zero_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_sign_matrix;
        int a_tab[8] = '{100, -100, 100, -100, -128, -128, 7, 0};
        int b_tab[8] = '{7, 7, -7, -7, -1, 1, 100, 5};
        logic [N-1:0] q_tab[8] = '{8'h0E, 8'hF2, 8'hF2, 8'h0E, 8'h80, 8'h80, 8'h00, 8'h00};
        logic [N-1:0] r_tab[8] = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h07, 8'h00};
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(N'(a_tab[i]), N'(b_tab[i]), q, r, z, lat);
            n_checks++;
            if (q !== q_tab[i] || r !== r_tab[i] || z !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL sign_case %0d/%0d: q=%h r=%h dbz=%0b, required q=%h r=%h dbz=0",
                         a_tab[i], b_tab[i], q, r, z, q_tab[i], r_tab[i]);
            end
            n_checks++;
            if (lat !== N + 1) begin
                n_fail++;
                $display("[TB] FAIL latency %0d/%0d: %0d edges, required %0d", a_tab[i], b_tab[i], lat, N + 1);
            end
        end
    endtask

    task automatic test_div_by_zero;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        int lat;
        run_op(8'd5, 8'd0, q, r, z, lat);
        n_checks++;
        if (q !== 8'hFF || r !== 8'h05 || z !== 1'b1 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL dbz_5_0: q=%h r=%h dbz=%0b lat=%0d, required q=ff r=05 dbz=1 lat=1", q, r, z, lat);
        end
        n_checks++;
        if (bus.quotient_out !== 8'hFF || bus.div_by_zero_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL dbz_hold: q=%h dbz=%0b, required q=ff dbz=1", bus.quotient_out, bus.div_by_zero_out);
        end
        run_op(8'h80, 8'd0, q, r, z, lat);
        n_checks++;
        if (q !== 8'hFF || r !== 8'h80 || z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL dbz_m128_0: q=%h r=%h dbz=%0b, required q=ff r=80 dbz=1", q, r, z);
        end
        run_op(8'd9, 8'd3, q, r, z, lat);
        n_checks++;
        if (q !== 8'd3 || r !== 8'd0 || z !== 1'b0 || lat !== N + 1) begin
            n_fail++;
            $display("[TB] FAIL dbz_clear: q=%h r=%h dbz=%0b lat=%0d, required q=03 r=00 dbz=0 lat=%0d",
                     q, r, z, lat, N + 1);
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        logic [N-1:0] q;
        logic [N-1:0] r;
        dones = 0;
        q = '0;
        r = '0;
        @(negedge clk_in);
        bus.dividend_in = 8'd100;
        bus.divisor_in  = 8'd7;
        bus.start_in    = 1'b1;
        @(posedge clk_in);
        #1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk_in);
            bus.start_in = (c == 3 || c == 9 || c == 10);
            if (bus.start_in) begin
                bus.dividend_in = 8'd50;
                bus.divisor_in  = 8'd5;
            end else begin
                bus.dividend_in = N'($urandom);
                bus.divisor_in  = N'($urandom);
            end
            @(posedge clk_in);
            #1;
            if (bus.done_out) begin
                dones++;
                q = bus.quotient_out;
                r = bus.remainder_out;
            end
        end
        bus.start_in = 1'b0;
        n_checks++;
        if (dones !== 1 || bus.busy_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ignore_start: dones=%0d busy=%0b, required dones=1 busy=0", dones, bus.busy_out);
        end
        n_checks++;
        if (q !== 8'd14 || r !== 8'd2) begin
            n_fail++;
            $display("[TB] FAIL ignore_result: q=%h r=%h, required q=0e r=02", q, r);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        int lat;
        dones = 0;
        @(negedge clk_in);
        bus.dividend_in = 8'd100;
        bus.divisor_in  = 8'd7;
        bus.start_in    = 1'b1;
        @(posedge clk_in);
        #1;
        bus.start_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy_out, bus.done_out, bus.quotient_out, bus.remainder_out, bus.div_by_zero_out} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_abort: busy=%0b done=%0b q=%h r=%h dbz=%0b, required all 0",
                     bus.busy_out, bus.done_out, bus.quotient_out, bus.remainder_out, bus.div_by_zero_out);
        end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk_in);
            #1;
            if (bus.done_out || bus.busy_out) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_done: %0d active cycles after abort, required 0", dones);
        end
        run_op(8'd20, 8'd6, q, r, z, lat);
        n_checks++;
        if (q !== 8'd3 || r !== 8'd2 || z !== 1'b0 || lat !== N + 1) begin
            n_fail++;
            $display("[TB] FAIL after_reset_20_6: q=%h r=%h dbz=%0b lat=%0d, required q=03 r=02 dbz=0 lat=%0d",
                     q, r, z, lat, N + 1);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic z;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic ez;
        int lat;
        for (int i = 0; i < 300; i++) begin
            a = N'($urandom);
            b = N'($urandom_range(1, (1 << N) - 1));
            model(a, b, eq, er, ez);
            run_op(a, b, q, r, z, lat);
            n_checks++;
            if (q !== eq || r !== er || z !== ez || lat !== N + 1) begin
                n_fail++;
                $display("[TB] FAIL random %0d/%0d: q=%h r=%h dbz=%0b lat=%0d, required q=%h r=%h dbz=%0b lat=%0d",
                         $signed(a), $signed(b), q, r, z, lat, eq, er, ez, N + 1);
            end
        end
    endtask

    initial begin
        bus.start_in    = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        test_reset();
        test_sign_matrix();
        test_div_by_zero();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
